// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single data-memory port between two requesters:
//   M0 - core load/store port
//   M1 - program-loader / debug port
// One access is in flight at a time. Simultaneous requests are resolved
// round-robin through rr_ptr (0 favours M0, 1 favours M1). All outputs are
// registered.
//
// Transaction timeline for a request seen in IDLE during cycle t:
//   t+1           ISSUE : mem_en=1 with the latched we/addr/wdata
//   t+2..t+1+LAT  WAIT  : reads only, MEM_LAT cycles
//   ACK cycle     : owner's ack=1 (t+2 for writes, t+2+MEM_LAT for reads)
//
// Parameters:
//   AW      address width of both requesters and the memory port
//   DW      data width
//   MEM_LAT cycles from the mem_en cycle to valid mem_rdata (1..15)
//
// Ports:
//   clk, reset                   clock, synchronous active-low reset
//   m0_req/we/addr/wdata         core request (req held until m0_ack)
//   m0_rdata, m0_ack             core read data and one-cycle completion pulse
//   m1_req/we/addr/wdata         loader request (req held until m1_ack)
//   m1_rdata, m1_ack             loader read data and one-cycle completion pulse
//   m1_lock                      (DMEM_ARB_LOCK_EN only) keep priority on M1
//   mem_en/we/addr/wdata         memory strobe and command
//   mem_rdata                    memory read data
//   busy                         high whenever the FSM is not in IDLE
//
// Optional feature macro: DMEM_ARB_LOCK_EN
//   When defined, m1_lock sampled in the ACK cycle of an M1 transaction keeps
//   rr_ptr on M1 so the loader wins the next tie (burst loading). M0 still
//   wins whenever M1 is not requesting.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_ack,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_ack,
`ifdef DMEM_ARB_LOCK_EN
    input  logic          m1_lock,
`endif
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    // WAIT counts down from MEM_LAT-1 to 0, giving exactly MEM_LAT cycles.
    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

    state_t        state_r, state_nx;
    logic          rr_ptr_r, rr_ptr_nx;
    logic          owner_r, owner_nx;
    logic [3:0]    lat_cnt_r, lat_cnt_nx;
    logic          grant_s;

    // The memory command registers double as the latched transaction.
    logic          mem_en_r, mem_en_nx;
    logic          mem_we_r, mem_we_nx;
    logic [AW-1:0] mem_addr_r, mem_addr_nx;
    logic [DW-1:0] mem_wdata_r, mem_wdata_nx;
    logic [DW-1:0] m0_rdata_r, m0_rdata_nx;
    logic [DW-1:0] m1_rdata_r, m1_rdata_nx;
    logic          m0_ack_r, m0_ack_nx;
    logic          m1_ack_r, m1_ack_nx;
    logic          busy_r, busy_nx;

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= IDLE;
            rr_ptr_r    <= 1'b0;
            owner_r     <= 1'b0;
            lat_cnt_r   <= 4'd0;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            m0_rdata_r  <= '0;
            m1_rdata_r  <= '0;
            m0_ack_r    <= 1'b0;
            m1_ack_r    <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nx;
            rr_ptr_r    <= rr_ptr_nx;
            owner_r     <= owner_nx;
            lat_cnt_r   <= lat_cnt_nx;
            mem_en_r    <= mem_en_nx;
            mem_we_r    <= mem_we_nx;
            mem_addr_r  <= mem_addr_nx;
            mem_wdata_r <= mem_wdata_nx;
            m0_rdata_r  <= m0_rdata_nx;
            m1_rdata_r  <= m1_rdata_nx;
            m0_ack_r    <= m0_ack_nx;
            m1_ack_r    <= m1_ack_nx;
            busy_r      <= busy_nx;
        end
    end

    // Next-state and next-output logic; outputs are computed one cycle early
    // so that every port is driven straight from a flop.
    always_comb begin
        state_nx     = state_r;
        rr_ptr_nx    = rr_ptr_r;
        owner_nx     = owner_r;
        lat_cnt_nx   = lat_cnt_r;
        mem_en_nx    = 1'b0;
        mem_we_nx    = mem_we_r;
        mem_addr_nx  = mem_addr_r;
        mem_wdata_nx = mem_wdata_r;
        m0_rdata_nx  = m0_rdata_r;
        m1_rdata_nx  = m1_rdata_r;
        m0_ack_nx    = 1'b0;
        m1_ack_nx    = 1'b0;

        // Tie goes to rr_ptr; otherwise whichever requester is active.
        grant_s = (m0_req && m1_req) ? rr_ptr_r : m1_req;

        case (state_r)
            IDLE: begin
                if (m0_req || m1_req) begin
                    owner_nx  = grant_s;
                    mem_en_nx = 1'b1;
                    state_nx  = ISSUE;
                    if (grant_s) begin
                        mem_we_nx    = m1_we;
                        mem_addr_nx  = m1_addr;
                        mem_wdata_nx = m1_wdata;
                    end else begin
                        mem_we_nx    = m0_we;
                        mem_addr_nx  = m0_addr;
                        mem_wdata_nx = m0_wdata;
                    end
                end else begin
                    state_nx = IDLE;
                end
            end
            ISSUE: begin
                if (mem_we_r) begin
                    m0_ack_nx = ~owner_r;
                    m1_ack_nx = owner_r;
                    state_nx  = ACK;
                end else begin
                    lat_cnt_nx = LAT_INIT;
                    state_nx   = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt_r == 4'd0) begin
                    if (owner_r) begin
                        m1_rdata_nx = mem_rdata;
                    end else begin
                        m0_rdata_nx = mem_rdata;
                    end
                    m0_ack_nx = ~owner_r;
                    m1_ack_nx = owner_r;
                    state_nx  = ACK;
                end else begin
                    lat_cnt_nx = lat_cnt_r - 4'd1;
                end
            end
            ACK: begin
                rr_ptr_nx = ~owner_r;
`ifdef DMEM_ARB_LOCK_EN
                // Loader keeps the tie-break while it asserts lock.
                if (owner_r && m1_lock) begin
                    rr_ptr_nx = 1'b1;
                end else begin
                    rr_ptr_nx = ~owner_r;
                end
`endif
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        busy_nx = (state_nx != IDLE);
    end

    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign m0_rdata  = m0_rdata_r;
    assign m1_rdata  = m1_rdata_r;
    assign m0_ack    = m0_ack_r;
    assign m1_ack    = m1_ack_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Randomised and directed stimulus for dmem_arbiter. A memory responder
// returns read data exactly MEM_LAT cycles after mem_en (garbage otherwise).
// A reference model predicts each grant from the request lines and a
// round-robin pointer, queues the expected ack (port, cycle, data) and a
// monitor pops and compares on every ack.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          m0_ack, m1_ack;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          busy;
`ifdef DMEM_ARB_LOCK_EN
    logic          m1_lock = 1'b0;
`endif

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack),
`ifdef DMEM_ARB_LOCK_EN
        .m1_lock(m1_lock),
`endif
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents seen by the responder, and the model's own copy.
    logic [DW-1:0] mem     [8];
    logic [DW-1:0] ref_mem [8];

    // Transaction each driver is currently presenting.
    logic          drv_we    [2];
    logic [AW-1:0] drv_addr  [2];
    logic [DW-1:0] drv_wdata [2];
    logic          granted   [2];

    typedef struct {
        int            port;
        logic          we;
        logic [DW-1:0] rdata;
        int            due;
    } exp_t;

    exp_t          exp_q[$];
    int            grant_log[$];
    int            en_cyc  [2];
    int            ack_cyc [2];
    logic [DW-1:0] ack_data[2];
    logic [DW-1:0] last_rd [2];
    logic          rr_m;
    logic          prev0, prev1;

    // ---------------- memory responder ----------------
    initial begin
        logic          rd_pend;
        int            rd_due;
        logic [DW-1:0] rd_val;
        rd_pend   = 1'b0;
        rd_due    = 0;
        rd_val    = '0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rd_pend && cyc == rd_due) begin
                mem_rdata = rd_val;
                rd_pend   = 1'b0;
            end else begin
                mem_rdata = $urandom();
            end
            if (reset && mem_en) begin
                if (mem_we) begin
                    mem[mem_addr[4:2]] = mem_wdata;
                end else begin
                    rd_pend = 1'b1;
                    rd_val  = mem[mem_addr[4:2]];
                    rd_due  = cyc + LAT;
                end
            end
        end
    end

    // ---------------- reference model + monitor ----------------
    initial begin
        exp_t e;
        int   own;
        int   ap;
        logic [DW-1:0] rd;
        prev0 = 1'b0; prev1 = 1'b0; rr_m = 1'b0;
        last_rd[0] = '0; last_rd[1] = '0;
        granted[0] = 1'b0; granted[1] = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                exp_q.delete();
                rr_m = 1'b0;
                last_rd[0] = '0;
                last_rd[1] = '0;
            end else begin
                total++;
                if (busy !== (mem_en || exp_q.size() > 0)) begin
                    bad++;
                    $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, (mem_en || exp_q.size() > 0));
                end
                if (mem_en) begin
                    own = (prev0 && prev1) ? int'(rr_m) : (prev1 ? 1 : (prev0 ? 0 : -1));
                    total++;
                    if (own < 0 || exp_q.size() != 0) begin
                        bad++;
                        $display("FAIL spurious_mem_en cyc=%0d got=1 want=0 (outstanding=%0d)", cyc, exp_q.size());
                    end else begin
                        if (mem_we !== drv_we[own] || mem_addr !== drv_addr[own] || mem_wdata !== drv_wdata[own]) begin
                            bad++;
                            $display("FAIL mem_cmd cyc=%0d got we=%b a=%h d=%h want port%0d we=%b a=%h d=%h",
                                     cyc, mem_we, mem_addr, mem_wdata, own, drv_we[own], drv_addr[own], drv_wdata[own]);
                        end
                        granted[own] = 1'b1;
                        grant_log.push_back(own);
                        en_cyc[own] = cyc;
                        e.port = own;
                        e.we   = drv_we[own];
                        e.due  = cyc + (drv_we[own] ? 1 : 1 + LAT);
                        if (drv_we[own]) begin
                            e.rdata = last_rd[own];
                            ref_mem[drv_addr[own][4:2]] = drv_wdata[own];
                        end else begin
                            e.rdata = ref_mem[drv_addr[own][4:2]];
                            last_rd[own] = e.rdata;
                        end
                        exp_q.push_back(e);
                    end
                end
                if (m0_ack || m1_ack) begin
                    total++;
                    if (m0_ack && m1_ack) begin
                        bad++;
                        $display("FAIL both_acks cyc=%0d got=11 want one", cyc);
                    end else if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_ack cyc=%0d got m0=%b m1=%b want none", cyc, m0_ack, m1_ack);
                    end else begin
                        e  = exp_q.pop_front();
                        ap = m1_ack ? 1 : 0;
                        rd = m1_ack ? m1_rdata : m0_rdata;
                        if (ap != e.port || cyc != e.due || rd !== e.rdata) begin
                            bad++;
                            $display("FAIL ack cyc=%0d got port%0d data=%h want port%0d cyc=%0d data=%h",
                                     cyc, ap, rd, e.port, e.due, e.rdata);
                        end
                        ack_cyc[ap]  = cyc;
                        ack_data[ap] = rd;
                        rr_m = (e.port == 0);
`ifdef DMEM_ARB_LOCK_EN
                        if (e.port == 1 && m1_lock) rr_m = 1'b1;
`endif
                    end
                end else if (exp_q.size() > 0) begin
                    if (cyc >= exp_q[0].due) begin
                        total++;
                        bad++;
                        $display("FAIL ack_missing cyc=%0d got none want port%0d", cyc, exp_q[0].port);
                        void'(exp_q.pop_front());
                    end
                end
            end
            prev0 = m0_req;
            prev1 = m1_req;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_port(input int p, input logic rq, input logic we,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            m0_req = rq; m0_we = we; m0_addr = a; m0_wdata = d;
        end else begin
            m1_req = rq; m1_we = we; m1_addr = a; m1_wdata = d;
        end
    endtask

    task automatic set_req(input int p, input logic rq);
        if (p == 0) m0_req = rq;
        else        m1_req = rq;
    endtask

    // Present one transaction, wait (bounded) for its ack. Entered and left
    // at posedge+1. With keep=1 req is left high for the caller.
    task automatic do_one(input int p, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic keep, output int t0);
        int   wt;
        logic ak;
        drv_we[p] = we; drv_addr[p] = a; drv_wdata[p] = d;
        granted[p] = 1'b0;
        set_port(p, 1'b1, we, a, d);
        t0 = cyc;
        wt = 0;
        while (1) begin
            @(negedge clk);
            wt++;
            ak = (p == 0) ? m0_ack : m1_ack;
            if (ak) break;
            if (wt > 200) begin
                total++;
                bad++;
                $display("FAIL ack_timeout port%0d got none want ack", p);
                break;
            end
            // Once granted, changes on the request bus must have no effect.
            if (granted[p]) set_port(p, 1'b1, ~we, $urandom(), $urandom());
        end
        @(posedge clk);
        #1;
        if (!keep) set_req(p, 1'b0);
    endtask

    task automatic drive(input int p, input int n, input int maxgap);
        int gap, t0;
        for (int i = 0; i < n; i++) begin
            gap = $urandom_range(0, maxgap);
            if (gap > 0) begin
                set_req(p, 1'b0);
                repeat (gap) @(posedge clk);
                #1;
            end
            do_one(p, 1'($urandom_range(0, 1)), {27'd0, 3'($urandom_range(0, 7)), 2'b00},
                   $urandom(), 1'b1, t0);
        end
        set_req(p, 1'b0);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        set_req(0, 1'b0);
        set_req(1, 1'b0);
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int t0;
        int wt;
        logic [8:0] grp;
        set_port(0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 8; i++) begin
            mem[i]     = 32'h1000_0000 + 32'(i);
            ref_mem[i] = 32'h1000_0000 + 32'(i);
        end
        drv_we[0] = 1'b0; drv_we[1] = 1'b0;
        drv_addr[0] = '0; drv_addr[1] = '0;
        drv_wdata[0] = '0; drv_wdata[1] = '0;

        // 1: reset, then idle with all outputs low.
        do_reset(2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            grp = {m0_ack, m1_ack, mem_en, mem_we, busy, |m0_rdata, |m1_rdata, |mem_addr, |mem_wdata};
            check("idle_outputs", 64'(grp), 64'd0);
        end
        @(posedge clk); #1;

        // 2: single M0 write.
        do_one(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, t0);
        check("wr_en_cycle", 64'(en_cyc[0] - t0), 64'd1);
        check("wr_ack_cycle", 64'(ack_cyc[0] - t0), 64'd2);

        // 3: single M1 read.
        mem[4] = 32'h1234_5678; ref_mem[4] = 32'h1234_5678;
        do_one(1, 1'b0, 32'h10, 32'h0, 1'b0, t0);
        check("rd_en_cycle", 64'(en_cyc[1] - t0), 64'd1);
        check("rd_ack_cycle", 64'(ack_cyc[1] - t0), 64'(2 + LAT));
        check("rd_data", 64'(ack_data[1]), 64'h1234_5678);

        // 4: contention straight after reset alternates starting with M0.
        do_reset(2);
        grant_log.delete();
        fork
            drive(0, 2, 0);
            drive(1, 2, 0);
        join
        check("rr_count", 64'(grant_log.size()), 64'd4);
        if (grant_log.size() == 4) begin
            check("rr_order", {32'(grant_log[0]), 8'(grant_log[1]), 8'(grant_log[2]), 8'(grant_log[3])},
                  {32'd0, 8'd1, 8'd0, 8'd1});
        end

        // 5: reset during WAIT abandons the read; a fresh read then works.
        do_reset(2);
        mem[2] = 32'hCAFE_0002; ref_mem[2] = 32'hCAFE_0002;
        drv_we[1] = 1'b0; drv_addr[1] = 32'h8; drv_wdata[1] = '0;
        granted[1] = 1'b0;
        set_port(1, 1'b1, 1'b0, 32'h8, '0);
        wt = 0;
        while (!granted[1] && wt < 50) begin
            @(posedge clk); #1;
            wt++;
        end
        check("mid_read_granted", 64'(granted[1]), 64'd1);
        reset = 1'b0;
        set_req(1, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("post_reset_quiet", 64'({busy, mem_en, m0_ack, m1_ack}), 64'd0);
        for (int i = 0; i < LAT + 4; i++) begin
            @(negedge clk);
            check("no_ack_after_reset", 64'({m0_ack, m1_ack}), 64'd0);
        end
        @(posedge clk); #1;
        do_one(1, 1'b0, 32'h8, 32'h0, 1'b0, t0);
        check("fresh_rd_ack_cycle", 64'(ack_cyc[1] - t0), 64'(2 + LAT));
        check("fresh_rd_data", 64'(ack_data[1]), 64'hCAFE_0002);

`ifdef DMEM_ARB_LOCK_EN
        // 6: lock keeps M1 winning ties; dropping it hands the tie to M0.
        do_reset(2);
        grant_log.delete();
        m1_lock = 1'b1;
        fork
            drive(0, 2, 0);
            drive(1, 4, 0);
            begin
                wt = 0;
                while (grant_log.size() < 4 && wt < 500) begin
                    @(posedge clk); #1;
                    wt++;
                end
                m1_lock = 1'b0;
            end
        join
        check("lock_count", 64'(grant_log.size()), 64'd6);
        if (grant_log.size() == 6) begin
            check("lock_order", {16'd0, 8'(grant_log[0]), 8'(grant_log[1]), 8'(grant_log[2]),
                                 8'(grant_log[3]), 8'(grant_log[4]), 8'(grant_log[5])},
                  {16'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd0, 8'd1});
        end
`endif

        // Random phase: both ports with random gaps, data, addresses.
        do_reset(2);
        fork
            drive(0, 60, 3);
            drive(1, 60, 3);
        join
        repeat (LAT + 4) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
